// File: rtl/csr_gpio_bank_pkg.sv
// Shared constants for the GPIO bank: register offsets within the window and read codes.
// Window decode helper is here so the bench and the bank agree on what "in window" means.
package csr_gpio_bank_pkg;

  localparam logic [4:0] GPIO_IN_OFS      = 5'h00;
  localparam logic [4:0] GPIO_OUT_OFS     = 5'h02;
  localparam logic [4:0] GPIO_OE_OFS      = 5'h04;
  localparam logic [4:0] GPIO_OUT_SET_OFS = 5'h06;
  localparam logic [4:0] GPIO_OUT_CLR_OFS = 5'h08;
  localparam logic [4:0] GPIO_RISE_EN_OFS = 5'h0A;
  localparam logic [4:0] GPIO_FALL_EN_OFS = 5'h0C;
  localparam logic [4:0] GPIO_PEND_OFS    = 5'h0E;
  localparam logic [4:0] GPIO_MASK_OFS    = 5'h10;

  localparam logic [15:0] RD_BADA = 16'hbada;
  localparam logic [15:0] RD_DEAD = 16'hdead;

  // Base is 32-byte aligned, so the upper address bits select the window.
  function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base);
    return (addr[15:5] == base[15:5]) && (addr[4:0] <= GPIO_MASK_OFS);
  endfunction

endpackage

// File: rtl/csr_gpio_bank_gpio_sync.sv
// Width x depth input synchroniser for asynchronous pins, active-low async reset.
module gpio_sync #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [DEPTH-1:0][W-1:0] sync_q;
  logic [DEPTH-1:0][W-1:0] sync_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign dout = sync_q[DEPTH-1];

endmodule

// File: rtl/csr_gpio_bank.sv
// GPIO control/status bank on the J1 I/O bus: OUT/OE with atomic set/clear, synchronised IN.
// With GPIO_IRQ_EN defined, adds edge capture into sticky PEND bits and a masked registered irq.
module csr_gpio_bank
  import csr_gpio_bank_pkg::*;
#(
  parameter int          GPIO_W      = 8,
  parameter logic [15:0] BASE_ADDR   = 16'h2000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       j1_mem_addr,
  input  logic [15:0]       j1_dout,
  input  logic              j1_io_wr,
  input  logic              j1_io_rd,
  output logic [15:0]       j1_io_din,
  output logic              hit,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);

  logic              win;
  logic [4:0]        ofs;
  logic [GPIO_W-1:0] wdata;
  logic [GPIO_W-1:0] sync_in;
  logic              unused_dout;

  assign ofs         = j1_mem_addr[4:0];
  assign win         = in_window(j1_mem_addr, BASE_ADDR);
  assign hit         = win & (j1_io_rd | j1_io_wr);
  assign wdata       = j1_dout[GPIO_W-1:0];
  assign unused_dout = ^j1_dout;

  function automatic logic wr_at(input logic [4:0] o);
    return j1_io_wr && win && (ofs == o);
  endfunction

  gpio_sync #(.W(GPIO_W), .DEPTH(SYNC_STAGES)) u_gpio_sync (
    .clk   (clk),
    .rst_n (rst),
    .din   (gpio_in),
    .dout  (sync_in)
  );

  logic [GPIO_W-1:0] out_q, out_d;
  logic [GPIO_W-1:0] oe_q,  oe_d;

  always_comb begin
    out_d = out_q;
    oe_d  = oe_q;
    if (wr_at(GPIO_OUT_OFS))     out_d = wdata;
    if (wr_at(GPIO_OUT_SET_OFS)) out_d = out_q | wdata;
    if (wr_at(GPIO_OUT_CLR_OFS)) out_d = out_q & ~wdata;
    if (wr_at(GPIO_OE_OFS))      oe_d  = wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
      oe_q  <= '0;
    end else begin
      out_q <= out_d;
      oe_q  <= oe_d;
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = oe_q;

`ifdef GPIO_IRQ_EN
  localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

  logic [GPIO_W-1:0] rise_en_q, rise_en_d;
  logic [GPIO_W-1:0] fall_en_q, fall_en_d;
  logic [GPIO_W-1:0] mask_q,    mask_d;
  logic [GPIO_W-1:0] pend_q,    pend_d;
  logic [GPIO_W-1:0] prev_q,    prev_d;
  logic [2:0]        warm_q,    warm_d;
  logic              irq_q,     irq_d;
  logic [GPIO_W-1:0] edge_hit;
  logic [GPIO_W-1:0] w1c;

  always_comb begin
    rise_en_d = wr_at(GPIO_RISE_EN_OFS) ? wdata : rise_en_q;
    fall_en_d = wr_at(GPIO_FALL_EN_OFS) ? wdata : fall_en_q;
    mask_d    = wr_at(GPIO_MASK_OFS)    ? wdata : mask_q;
    prev_d    = sync_in;
    warm_d    = (warm_q == WARM_MAX) ? warm_q : warm_q + 3'd1;
    // Until the chain and prev have refilled after reset, a held-high pin looks like a rise.
    edge_hit  = '0;
    if (warm_q == WARM_MAX)
      edge_hit = (sync_in & ~prev_q & rise_en_q) | (~sync_in & prev_q & fall_en_q);
    w1c       = wr_at(GPIO_PEND_OFS) ? wdata : '0;
    pend_d    = (pend_q & ~w1c) | edge_hit;
    irq_d     = |(pend_q & mask_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_en_q <= '0;
      fall_en_q <= '0;
      mask_q    <= '0;
      pend_q    <= '0;
      prev_q    <= '0;
      warm_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      prev_q    <= prev_d;
      warm_q    <= warm_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    j1_io_din = RD_BADA;
    if (!j1_io_rd) begin
      j1_io_din = RD_DEAD;
    end else if (win) begin
      case (ofs)
        GPIO_IN_OFS:      j1_io_din = 16'(sync_in);
        GPIO_OUT_OFS:     j1_io_din = 16'(out_q);
        GPIO_OE_OFS:      j1_io_din = 16'(oe_q);
`ifdef GPIO_IRQ_EN
        GPIO_RISE_EN_OFS: j1_io_din = 16'(rise_en_q);
        GPIO_FALL_EN_OFS: j1_io_din = 16'(fall_en_q);
        GPIO_PEND_OFS:    j1_io_din = 16'(pend_q);
        GPIO_MASK_OFS:    j1_io_din = 16'(mask_q);
`endif
        default:          j1_io_din = RD_BADA;
      endcase
    end
  end

endmodule
